decrypted_write_buffer: RTL and testbench
=========================================

# decrypted_write_buffer

Write buffer between the address decoder's decrypted-image write port and the single-port pixel RAM holding the decrypted image. It absorbs processor stores (one pixel per store, already converted to a pixel index by the decoder) in a small FIFO, drains them into the pixel RAM whenever the display reader is not using it, and back-pressures the core with a stall when full. The display reader always has priority on the RAM.

## Interface
- N, 32: processor data/address width
- AW, 15: pixel RAM address width (19200 pixels)
- DEPTH, 4: FIFO entries, power of two, at least 2
- clk  in  1  system clock, all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- wr_en  in  1  decrypted write enable from the address decoder
- wr_address  in  N  pixel index from the decoder; high-Z when wr_en=0, so sampled only when wr_en=1
- wr_data  in  N  store data; bits [7:0] form the pixel, bits [N-1:8] are ignored
- stall  out  1  buffer full; core must hold the store
- mem_busy  in  1  display reader owns the pixel RAM this cycle
- mem_we  out  1  pixel RAM write strobe, one cycle per pixel
- mem_address  out  AW  pixel RAM address
- mem_data  out  8  pixel value
- error  out  1  sticky out-of-range flag (see Configuration)

## Operation
- FIFO of DEPTH entries {address[AW-1:0], pixel[7:0]}, with count 0..DEPTH.
- Push: wr_en=1 and count<DEPTH. wr_address[AW-1:0] and wr_data[7:0] are stored at the tail. wr_en=1 with count==DEPTH is ignored; the core holds the store because stall=1.
- Pop: count>0 and mem_busy=0. The head entry is registered into mem_address/mem_data, mem_we=1 for the following cycle, and the head advances.
- No pop (empty or mem_busy=1): mem_we=0 next cycle. mem_address and mem_data hold their last values.
- Push and pop in the same cycle: count unchanged. When count==DEPTH, a pop does not free a slot for a same-cycle push; stall decides acceptance.
- stall = (count==DEPTH), decoded combinationally from registered count.
- Pointers wrap modulo DEPTH. Count never exceeds DEPTH or drops below 0.
- Order preserved: RAM writes occur in push order, including repeated writes to one address.

## Timing
- Reset values: count=0, pointers=0, mem_we=0, mem_address=0, mem_data=0, error=0, stall=0.
- Latency with an empty FIFO and mem_busy=0: push on edge t gives pop on edge t+1, so mem_we is high in the cycle after edge t+1.
- Throughput: one pixel per cycle, sustained while mem_busy=0.
- mem_busy is sampled at the pop edge only. A strobe already issued completes even if mem_busy rises in that cycle. The reader must raise mem_busy one cycle before it needs the RAM.
- Reset mid-operation discards all buffered entries, and mem_we is 0 in the cycle after the reset edge.

## Configuration
- DECRYPTED_BOUNDS_CHECK_EN defined:
  - A push with wr_address ≥ PIXEL_COUNT (19200) is not stored.
  - error is set to 1 on the next edge and holds until rst.
  - stall is unaffected.
- Undefined:
  - Every accepted push is stored with truncated address bits [AW-1:0].
  - error is tied to 0.

## Structure
- Package decrypt_pkg:
  - IMG_WIDTH=160, IMG_HEIGHT=120, PIXEL_COUNT=19200, PIXEL_W=8
  - typedef pixel_t (8-bit)
  - packed struct wbuf_entry_t {address, pixel}
- Sub-module sync_fifo: parameterised by DEPTH and entry type, with push/pop/count/full/empty. The top level holds the pop/strobe register stage and the bounds check.

## Test plan
- Single write: wr_en=1 with wr_address=0x10 and wr_data=0x123456AB; mem_busy=0. Expect mem_we high exactly one cycle, two edges later, with mem_address=0x10 and mem_data=0xAB.
- Fill under busy: mem_busy=1; push 5 writes with addresses 1..5 on consecutive cycles. Expect stall=1 after the 4th; the 5th is not stored; no mem_we. Release mem_busy, then expect 4 strobes on addresses 1,2,3,4 in order on consecutive cycles.
- Streaming: push every cycle with mem_busy=0 for 20 cycles. Expect stall never asserted, 20 strobes, and data order matching the stimulus.
- Busy mid-drain: 3 entries queued; mem_busy=1 for 2 cycles after the first pop. Expect the first strobe to complete, a 2-cycle gap, then the remaining 2 strobes.
- Reset mid-operation: 3 entries queued, then rst=1 for one cycle. Expect mem_we=0 and stall=0 afterwards, and no stale strobes.
- Bounds check (macro on): push wr_address=19200. Expect no mem_we and error=1, still held after 10 further cycles. With the macro off, expect a strobe at address 19200 & 0x7FFF.

Source files
------------

// File: rtl/decrypt_pkg.sv
// decrypt_pkg: shared image geometry, pixel type and write-buffer entry layout
// for the decrypted-image path.
// No ports; imported by sync_fifo and decrypted_write_buffer.
package decrypt_pkg;

  localparam int unsigned IMG_WIDTH   = 160;
  localparam int unsigned IMG_HEIGHT  = 120;
  localparam int unsigned PIXEL_COUNT = IMG_WIDTH * IMG_HEIGHT;
  localparam int unsigned PIXEL_W     = 8;
  localparam int unsigned ADDR_W      = 15;

  typedef logic [PIXEL_W-1:0] pixel_t;

  // One buffered store: pixel RAM address plus pixel value
  typedef struct packed {
    logic [ADDR_W-1:0] address;
    pixel_t            pixel;
  } wbuf_entry_t;

endpackage : decrypt_pkg

// File: rtl/decrypted_write_buffer_sync_fifo.sv
// sync_fifo: single-clock FIFO of DEPTH entries of type entry_t.
// Ports:
//   i_clk, i_rst    clock, synchronous active-high reset
//   i_push, i_data  write request / tail data (ignored while full)
//   i_pop           read request (ignored while empty)
//   o_data          head entry, valid while !o_empty
//   o_count         occupancy 0..DEPTH
//   o_full, o_empty status decoded from the registered count
module sync_fifo
  import decrypt_pkg::*;
#(
  parameter int unsigned DEPTH   = 4,
  parameter type         entry_t = wbuf_entry_t
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic                       i_push,
  input  entry_t                     i_data,
  input  logic                       i_pop,
  output entry_t                     o_data,
  output logic [$clog2(DEPTH+1)-1:0] o_count,
  output logic                       o_full,
  output logic                       o_empty
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  entry_t          r_mem [DEPTH];
  logic [PW-1:0]   r_wr_ptr;
  logic [PW-1:0]   r_rd_ptr;
  logic [CW-1:0]   r_count;

  logic w_do_push;
  logic w_do_pop;

  // A pop never frees a slot for a same-cycle push when full
  assign w_do_push = i_push && (r_count != CW'(DEPTH));
  assign w_do_pop  = i_pop  && (r_count != CW'(0));

  // Pointer and occupancy tracking; pointers wrap since DEPTH is a power of two
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage array, no reset needed: contents are qualified by r_count
  always_ff @(posedge i_clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_data;
  end

  assign o_data  = r_mem[r_rd_ptr];
  assign o_count = r_count;
  assign o_full  = (r_count == CW'(DEPTH));
  assign o_empty = (r_count == CW'(0));

endmodule : sync_fifo

// File: rtl/decrypted_write_buffer.sv
// decrypted_write_buffer: buffers decoder pixel stores and drains them into the
// single-port pixel RAM whenever the display reader is not using it.
// Ports:
//   i_clk, i_rst      clock, synchronous active-high reset
//   i_wr_en           store enable from the address decoder
//   i_wr_address      pixel index (sampled only when i_wr_en=1)
//   i_wr_data         store data, bits [7:0] are the pixel
//   o_stall           buffer full, core must hold the store
//   i_mem_busy        display reader owns the RAM (sampled at the pop edge)
//   o_mem_we          registered RAM write strobe, one cycle per pixel
//   o_mem_address     registered RAM address
//   o_mem_data        registered pixel value
//   o_error           sticky out-of-range flag
// Build option: DECRYPTED_BOUNDS_CHECK_EN drops stores with address >= PIXEL_COUNT
// and raises o_error; when undefined, addresses are truncated and o_error is 0.
module decrypted_write_buffer
  import decrypt_pkg::*;
#(
  parameter int unsigned N     = 32,
  parameter int unsigned AW    = ADDR_W,
  parameter int unsigned DEPTH = 4
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_wr_en,
  input  logic [N-1:0]  i_wr_address,
  input  logic [N-1:0]  i_wr_data,
  output logic          o_stall,
  input  logic          i_mem_busy,
  output logic          o_mem_we,
  output logic [AW-1:0] o_mem_address,
  output logic [7:0]    o_mem_data,
  output logic          o_error
);

  localparam int unsigned CW = $clog2(DEPTH + 1);

  wbuf_entry_t    w_in_entry;
  wbuf_entry_t    w_head;
  logic [CW-1:0]  w_unused_count;
  logic           w_full;
  logic           w_empty;
  logic           w_in_range;
  logic           w_push;
  logic           w_pop;
  logic           w_unused;

  logic           r_mem_we;
  logic [AW-1:0]  r_mem_address;
  pixel_t         r_mem_data;
  logic           r_error;

  assign w_in_entry.address = i_wr_address[ADDR_W-1:0];
  assign w_in_entry.pixel   = i_wr_data[PIXEL_W-1:0];

`ifdef DECRYPTED_BOUNDS_CHECK_EN
  assign w_in_range = (i_wr_address < N'(PIXEL_COUNT));
`else
  assign w_in_range = 1'b1;
`endif

  // Full-cycle stores are held by the core, so only non-full cycles count
  assign w_push = i_wr_en && !w_full && w_in_range;
  assign w_pop  = !w_empty && !i_mem_busy;

  // Upper data/address bits are intentionally discarded
  assign w_unused = ^{i_wr_data[N-1:PIXEL_W], i_wr_address[N-1:ADDR_W], w_unused_count};

  sync_fifo #(
    .DEPTH   (DEPTH),
    .entry_t (wbuf_entry_t)
  ) u_fifo (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_push  (w_push),
    .i_data  (w_in_entry),
    .i_pop   (w_pop),
    .o_data  (w_head),
    .o_count (w_unused_count),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  // Strobe stage: head entry registered toward the RAM on each pop
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_mem_we      <= 1'b0;
      r_mem_address <= '0;
      r_mem_data    <= '0;
    end else begin
      r_mem_we <= w_pop;
      if (w_pop) begin
        r_mem_address <= AW'(w_head.address);
        r_mem_data    <= w_head.pixel;
      end
    end
  end

  // Sticky out-of-range flag
`ifdef DECRYPTED_BOUNDS_CHECK_EN
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_error <= 1'b0;
    end else if (i_wr_en && !w_full && !w_in_range) begin
      r_error <= 1'b1;
    end
  end
`else
  assign r_error = 1'b0;
`endif

  assign o_stall       = w_full;
  assign o_mem_we      = r_mem_we;
  assign o_mem_address = r_mem_address;
  assign o_mem_data    = r_mem_data;
  assign o_error       = r_error;

endmodule : decrypted_write_buffer

// File: tb/tb_decrypted_write_buffer.sv
// Scoreboard bench for decrypted_write_buffer: expected strobes are queued at
// stimulus time and a negedge monitor pops/compares on every o_mem_we.
module tb_decrypted_write_buffer;
  import decrypt_pkg::*;

  logic        clk;
  logic        rst;
  logic        wr_en;
  logic [31:0] wr_address;
  logic [31:0] wr_data;
  logic        stall;
  logic        mem_busy;
  logic        mem_we;
  logic [14:0] mem_address;
  logic [7:0]  mem_data;
  logic        error;

  int n_tests = 0;
  int n_fail  = 0;
  int n_strobes = 0;

  wbuf_entry_t exp_q[$];

  decrypted_write_buffer #(.N(32), .AW(15), .DEPTH(4)) dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .i_wr_en       (wr_en),
    .i_wr_address  (wr_address),
    .i_wr_data     (wr_data),
    .o_stall       (stall),
    .i_mem_busy    (mem_busy),
    .o_mem_we      (mem_we),
    .o_mem_address (mem_address),
    .o_mem_data    (mem_data),
    .o_error       (error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Advance one edge; inputs change 1 time unit after the edge
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_wr(input logic [14:0] a, input logic [7:0] d);
    wbuf_entry_t e;
    e.address = a;
    e.pixel   = d;
    exp_q.push_back(e);
  endtask

  task automatic drive(input logic [31:0] a, input logic [31:0] d);
    wr_en      = 1'b1;
    wr_address = a;
    wr_data    = d;
  endtask

  task automatic idle();
    wr_en      = 1'b0;
    wr_address = 'z;
    wr_data    = '0;
  endtask

  // Monitor: every strobe must match the oldest expected store
  always @(negedge clk) begin
    if (mem_we === 1'b1) begin
      wbuf_entry_t e;
      n_strobes++;
      if (exp_q.size() == 0) begin
        chk("unexpected_strobe", {17'd0, mem_address}, 32'hFFFF_FFFF);
      end else begin
        e = exp_q.pop_front();
        chk("strobe_addr", {17'd0, mem_address}, {17'd0, e.address});
        chk("strobe_data", {24'd0, mem_data}, {24'd0, e.pixel});
      end
    end
  end

  initial begin
    int s0;
    rst      = 1'b1;
    mem_busy = 1'b0;
    idle();
    cyc();
    cyc();
    chk("rst_mem_we",   {31'd0, mem_we}, 32'd0);
    chk("rst_mem_addr", {17'd0, mem_address}, 32'd0);
    chk("rst_mem_data", {24'd0, mem_data}, 32'd0);
    chk("rst_stall",    {31'd0, stall}, 32'd0);
    chk("rst_error",    {31'd0, error}, 32'd0);
    rst = 1'b0;
    cyc();

    // Single write: strobe exactly one cycle, two edges after push
    s0 = n_strobes;
    drive(32'h10, 32'h1234_56AB);
    expect_wr(15'h10, 8'hAB);
    cyc();
    idle();
    chk("single_we_after_push", {31'd0, mem_we}, 32'd0);
    cyc();
    chk("single_we_pop", {31'd0, mem_we}, 32'd1);
    cyc();
    chk("single_we_done", {31'd0, mem_we}, 32'd0);
    cyc();
    chk("single_count", n_strobes - s0, 1);

    // Fill under busy: 4 stored, 5th dropped by stall
    mem_busy = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      drive(i, 32'h20 + i);
      if (i <= 4) expect_wr(15'(i), 8'(32'h20 + i));
      chk("fill_stall_before", {31'd0, stall}, (i == 5) ? 32'd1 : 32'd0);
      cyc();
    end
    idle();
    chk("fill_stall_held", {31'd0, stall}, 32'd1);
    chk("fill_no_we", {31'd0, mem_we}, 32'd0);
    mem_busy = 1'b0;
    for (int i = 0; i < 4; i++) begin
      cyc();
      chk("fill_drain_we", {31'd0, mem_we}, 32'd1);
      chk("fill_drain_stall", {31'd0, stall}, 32'd0);
    end
    cyc();
    chk("fill_drain_end", {31'd0, mem_we}, 32'd0);

    // Streaming: one push per cycle, never stalls
    s0 = n_strobes;
    for (int i = 0; i < 20; i++) begin
      drive(32'h100 + i, {24'(i), 8'(i * 7 + 3)});
      expect_wr(15'(32'h100 + i), 8'(i * 7 + 3));
      cyc();
      chk("stream_stall", {31'd0, stall}, 32'd0);
    end
    idle();
    cyc();
    cyc();
    cyc();
    chk("stream_count", n_strobes - s0, 20);

    // Busy mid-drain: first strobe completes, 2-cycle gap, then the rest
    mem_busy = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(32'h200 + i, 32'h40 + i);
      expect_wr(15'(32'h200 + i), 8'(32'h40 + i));
      cyc();
    end
    idle();
    mem_busy = 1'b0;
    cyc();
    mem_busy = 1'b1;
    chk("mid_we1", {31'd0, mem_we}, 32'd1);
    cyc();
    chk("mid_gap1", {31'd0, mem_we}, 32'd0);
    cyc();
    chk("mid_gap2", {31'd0, mem_we}, 32'd0);
    mem_busy = 1'b0;
    cyc();
    chk("mid_we2", {31'd0, mem_we}, 32'd1);
    cyc();
    chk("mid_we3", {31'd0, mem_we}, 32'd1);
    cyc();
    chk("mid_end", {31'd0, mem_we}, 32'd0);

    // Reset mid-operation: one strobe in flight, two entries discarded
    mem_busy = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(32'h300 + i, 32'h60 + i);
      cyc();
    end
    idle();
    expect_wr(15'h300, 8'h60);
    mem_busy = 1'b0;
    cyc();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    chk("rst_mid_we", {31'd0, mem_we}, 32'd0);
    chk("rst_mid_stall", {31'd0, stall}, 32'd0);
    chk("rst_mid_addr", {17'd0, mem_address}, 32'd0);
    for (int i = 0; i < 5; i++) begin
      cyc();
      chk("rst_no_stale", {31'd0, mem_we}, 32'd0);
    end

    // Bounds: last valid index always stored
    drive(32'd19199, 32'h77);
    expect_wr(15'd19199, 8'h77);
    cyc();
    idle();
    cyc();
    cyc();
    chk("bound_last_error", {31'd0, error}, 32'd0);

    // Bounds: first out-of-range index
    drive(32'd19200, 32'h5A);
`ifndef DECRYPTED_BOUNDS_CHECK_EN
    expect_wr(15'(32'd19200 & 32'h7FFF), 8'h5A);
`endif
    cyc();
    idle();
    cyc();
`ifdef DECRYPTED_BOUNDS_CHECK_EN
    chk("bound_error_set", {31'd0, error}, 32'd1);
`else
    chk("bound_error_off", {31'd0, error}, 32'd0);
`endif
    for (int i = 0; i < 10; i++) cyc();
`ifdef DECRYPTED_BOUNDS_CHECK_EN
    chk("bound_error_held", {31'd0, error}, 32'd1);
`else
    chk("bound_error_off_held", {31'd0, error}, 32'd0);
`endif
    chk("bound_stall", {31'd0, stall}, 32'd0);

    chk("queue_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_decrypted_write_buffer
